l2_cache_wb: RTL and testbench
==============================

Name: l2_cache_wb

Overview:
Parametrised set-associative write-back, write-allocate L2 cache between the L1 refill/writeback port and main memory. It adds write-hit merging, dirty-line eviction, true-LRU replacement, a configurable lookup latency and hit/miss/writeback statistics counters. Upstream and downstream traffic use explicit valid/ready handshakes.

Parameters:
DATA_WIDTH, 32, word width in bits (multiple of 8, power of 2)
ADDR_WIDTH, 32, byte address width
NUM_SETS, 16, sets (power of 2, >=2)
NUM_WAYS, 4, ways per set (power of 2, 2..8)
BLOCK_WORDS, 16, words per L2 line (power of 2)
L1_WORDS, 4, words per L1 block (power of 2, <= BLOCK_WORDS)
HIT_LATENCY, 2, LOOKUP cycles (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  upstream request
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = write L1 block, 0 = read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  L1_WORDS*DATA_WIDTH  write block, word 0 in LSBs
resp_valid  out  1  one-cycle response pulse
resp_hit  out  1  response was a hit; valid with resp_valid
resp_rdata  out  L1_WORDS*DATA_WIDTH  read block; valid with resp_valid
mem_addr  out  ADDR_WIDTH  line-aligned memory address
mem_wdata  out  BLOCK_WORDS*DATA_WIDTH  evicted line
mem_read  out  1  refill request
mem_write  out  1  writeback request
mem_ready  in  1  completes the current mem_read/mem_write; read data valid that cycle
mem_rdata  in  BLOCK_WORDS*DATA_WIDTH  refill line
hit_cnt, miss_cnt, wb_cnt  out  32 each  saturating statistics counters

Behaviour:
- Address split: WB = log2(DATA_WIDTH/8). Line offset = addr[log2(BLOCK_WORDS)+WB-1:0]. Index is the next log2(NUM_SETS) bits. Tag is the remaining upper bits.
- L1 sub-block = addr[WB+log2(BLOCK_WORDS)-1 : WB+log2(L1_WORDS)]. The sub-block is aligned, selecting L1_WORDS consecutive words of the line. Lower address bits are ignored.
- Per line: data, tag, valid, dirty, age (log2(NUM_WAYS) bits).
- req_ready = 1 only in IDLE. The request (addr, write, wdata) is registered on acceptance and held internally until the response.
- States:
  - IDLE: on handshake go to LOOKUP.
  - LOOKUP: counts HIT_LATENCY cycles, then compares tags.
    - Hit: go to RESPOND.
    - Miss with victim valid && dirty: go to WRITEBACK.
    - Other miss: go to REFILL.
  - WRITEBACK: mem_write=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line. On mem_ready, clear the victim's dirty bit, wb_cnt++, go to REFILL.
  - REFILL: mem_read=1, mem_addr={tag, index, 0}. On mem_ready, install mem_rdata into the victim way, set valid, set tag, set dirty=0, go to RESPOND.
  - RESPOND: resp_valid=1 for one cycle, then IDLE.
- mem_read/mem_write are never asserted together. Each is held until mem_ready is sampled high, and drops the following cycle. mem_ready outside WRITEBACK/REFILL is ignored.
- Write (hit or after refill): merge req_wdata into the selected sub-block and set dirty=1. resp_rdata returns the merged sub-block.
- Read: resp_rdata is the selected sub-block of the line.
- resp_hit = 1 iff the tag matched in LOOKUP. hit_cnt or miss_cnt increments once per request at the end of LOOKUP. All counters saturate at 2^32-1.
- Timing: a hit accepted in cycle k gives resp_valid in cycle k+HIT_LATENCY+1, and req_ready is high again at k+HIT_LATENCY+2. A miss adds the mem handshake cycles.
- Victim selection: lowest-index invalid way; otherwise the way with age == NUM_WAYS-1.
- LRU update (on hit and on install): ways with age < accessed way's age increment, and the accessed way is set to 0. A refill followed by a write merge is a single update.
- Reset (any time, including mid-WRITEBACK/REFILL):
  - Outputs: all outputs and counters 0, except req_ready=1 after reset.
  - Cache state: valid and dirty cleared, age[w]=w, state=IDLE. Any in-flight request is dropped with no response; dirty data is discarded.
- Memory model: memory is read-only during LOOKUP/RESPOND; tag/data arrays are registers.

Test Plan:
1. Cold read of 0x00000040, memory returns word i = 0x100+i after 3 cycles. Required: mem_read with mem_addr=0x40; resp_hit=0; resp_rdata words = 0x100..0x103; miss_cnt=1; no mem_write.
2. Read 0x00000050 after test 1. Required: resp_valid exactly 3 cycles after acceptance; resp_hit=1; words 0x104..0x107; no mem activity; hit_cnt=1.
3. Write 0x00000040 with words 0xAAAA0000..0xAAAA0003, then read 0x40. Required: both resp_hit=1; read returns the written words; no mem activity.
4. Eviction sequence in set 0:
   - Read 0x0000, 0x0400, 0x0800, 0x0C00; write 0x0000 with 0xBEEF000i.
   - Read 0x0400, 0x0800, 0x0C00, then read 0x1000.
   - Required: mem_write with mem_addr=0x0000, mem_wdata words 0..3 = 0xBEEF0000..3; then mem_read 0x1000; wb_cnt=1.
5. Read 0x1400 next. Required: the victim is way holding 0x0400 (clean LRU); no mem_write; mem_read 0x1400 only.
6. Read miss with mem_ready withheld 10 cycles; pulse rst_n low during REFILL. Required: mem_read, resp_valid, counters 0 immediately; req_ready=1 after release; re-reading 0x00000040 misses.

Source files
------------

// File: rtl/l2_cache_wb_if.sv
// l2_cache_wb_if: upstream request/response and downstream memory handshake bundle for l2_cache_wb
interface l2_cache_wb_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int L1_WORDS    = 4,
  parameter int BLOCK_WORDS = 16
);
  logic                            req_valid;
  logic                            req_ready;
  logic                            req_write;
  logic [ADDR_WIDTH-1:0]           req_addr;
  logic [L1_WORDS*DATA_WIDTH-1:0]  req_wdata;
  logic                            resp_valid;
  logic                            resp_hit;
  logic [L1_WORDS*DATA_WIDTH-1:0]  resp_rdata;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_wdata;
  logic                            mem_read;
  logic                            mem_write;
  logic                            mem_ready;
  logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_rdata;
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_hit, resp_rdata, mem_addr, mem_wdata, mem_read, mem_write
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_hit, resp_rdata, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/l2_cache_wb.sv
// l2_cache_wb: set-associative write-back/write-allocate L2 with true-LRU, dirty eviction and stats
module l2_cache_wb #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 16,
  parameter int L1_WORDS    = 4,
  parameter int HIT_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  l2_cache_wb_if.slave bus,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] wb_cnt
);
  localparam int WB   = $clog2(DATA_WIDTH / 8);
  localparam int OB   = $clog2(BLOCK_WORDS);
  localparam int L1B  = $clog2(L1_WORDS);
  localparam int IB   = $clog2(NUM_SETS);
  localparam int TW   = ADDR_WIDTH - IB - OB - WB;
  localparam int AW   = $clog2(NUM_WAYS);
  localparam int LW   = BLOCK_WORDS * DATA_WIDTH;
  localparam int SW   = L1_WORDS * DATA_WIDTH;
  localparam int SUBW = (BLOCK_WORDS > L1_WORDS) ? $clog2(BLOCK_WORDS / L1_WORDS) : 1;
  localparam int CW   = $clog2(HIT_LATENCY + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_REFILL, S_RESP} state_e;

  state_e                                   state_q, state_d;
  logic [CW-1:0]                            cnt_q, cnt_d;
  logic [AW-1:0]                            way_q, way_d;
  logic [ADDR_WIDTH-1:0]                    req_addr_q, req_addr_d;
  logic                                     req_write_q, req_write_d;
  logic [SW-1:0]                            req_wdata_q, req_wdata_d;
  logic                                     req_ready_q, req_ready_d;
  logic                                     resp_valid_q, resp_valid_d;
  logic                                     resp_hit_q, resp_hit_d;
  logic [SW-1:0]                            resp_rdata_q, resp_rdata_d;
  logic [ADDR_WIDTH-1:0]                    mem_addr_q, mem_addr_d;
  logic [LW-1:0]                            mem_wdata_q, mem_wdata_d;
  logic                                     mem_read_q, mem_read_d;
  logic                                     mem_write_q, mem_write_d;
  logic [31:0]                              hit_cnt_q, hit_cnt_d;
  logic [31:0]                              miss_cnt_q, miss_cnt_d;
  logic [31:0]                              wb_cnt_q, wb_cnt_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]        valid_q, valid_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]        dirty_q, dirty_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][AW-1:0] age_q, age_d;
  logic [LW-1:0]                            data_q [NUM_SETS][NUM_WAYS];
  logic [TW-1:0]                            tag_q  [NUM_SETS][NUM_WAYS];

  logic [IB-1:0]   idx;
  logic [TW-1:0]   tag;
  logic [SUBW-1:0] sub;
  logic            hit;
  logic [AW-1:0]   hit_way, victim, way_sel;
  logic [LW-1:0]   line_src, line_new;
  logic            line_we, lru_upd;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign idx     = req_addr_q[WB+OB +: IB];
  assign tag     = req_addr_q[ADDR_WIDTH-1 -: TW];
  assign sub     = (BLOCK_WORDS > L1_WORDS) ? SUBW'(req_addr_q >> (WB + L1B)) : '0;
  assign way_sel = (state_q == S_LOOKUP) ? (hit ? hit_way : victim) : way_q;
  assign line_src = (state_q == S_REFILL) ? bus.mem_rdata : data_q[idx][way_sel];

  // tag match and victim choice: lowest invalid way wins over the oldest way
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = AW'(w);
      end
    victim = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (age_q[idx][w] == AW'(NUM_WAYS - 1)) victim = AW'(w);
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_q[idx][w]) victim = AW'(w);
  end

  // line after an optional write merge into the addressed L1 sub-block
  always_comb begin
    line_new = line_src;
    if (req_write_q) line_new[sub*SW +: SW] = req_wdata_q;
  end

  // next-state, bookkeeping and registered-output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    way_d        = way_q;
    req_addr_d   = req_addr_q;
    req_write_d  = req_write_q;
    req_wdata_d  = req_wdata_q;
    resp_hit_d   = resp_hit_q;
    resp_rdata_d = resp_rdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    wb_cnt_d     = wb_cnt_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    age_d        = age_q;
    line_we      = 1'b0;
    lru_upd      = 1'b0;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        state_d     = S_LOOKUP;
        cnt_d       = '0;
        req_addr_d  = bus.req_addr;
        req_write_d = bus.req_write;
        req_wdata_d = bus.req_wdata;
      end
      S_LOOKUP: if (cnt_q != CW'(HIT_LATENCY - 1)) cnt_d = cnt_q + CW'(1);
      else begin
        way_d      = way_sel;
        resp_hit_d = hit;
        if (hit) begin
          state_d   = S_RESP;
          hit_cnt_d = sat_inc(hit_cnt_q);
          line_we   = req_write_q;
          lru_upd   = 1'b1;
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          state_d    = (valid_q[idx][victim] && dirty_q[idx][victim]) ? S_WB : S_REFILL;
        end
      end
      S_WB: if (bus.mem_ready) begin
        dirty_d[idx][way_q] = 1'b0;
        wb_cnt_d = sat_inc(wb_cnt_q);
        state_d  = S_REFILL;
      end
      S_REFILL: if (bus.mem_ready) begin
        line_we = 1'b1;
        lru_upd = 1'b1;
        valid_d[idx][way_q] = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (line_we) dirty_d[idx][way_sel] = req_write_q;
    if (lru_upd) begin
      for (int w = 0; w < NUM_WAYS; w++)
        if (age_q[idx][w] < age_q[idx][way_sel]) age_d[idx][w] = age_q[idx][w] + AW'(1);
      age_d[idx][way_sel] = '0;
      resp_rdata_d = line_new[sub*SW +: SW];
    end
    req_ready_d  = state_d == S_IDLE;
    resp_valid_d = state_d == S_RESP;
    mem_read_d   = state_d == S_REFILL;
    mem_write_d  = state_d == S_WB;
    mem_addr_d   = (state_d == S_WB)     ? ADDR_WIDTH'({tag_q[idx][way_sel], idx}) << (OB + WB) :
                   (state_d == S_REFILL) ? ADDR_WIDTH'({tag, idx}) << (OB + WB) : '0;
    mem_wdata_d  = (state_d == S_WB) ? data_q[idx][way_sel] : '0;
  end

  // control state, line status and outputs; reset drops any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      way_q        <= '0;
      req_addr_q   <= '0;
      req_write_q  <= 1'b0;
      req_wdata_q  <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      wb_cnt_q     <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= AW'(w);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      way_q        <= way_d;
      req_addr_q   <= req_addr_d;
      req_write_q  <= req_write_d;
      req_wdata_q  <= req_wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      age_q        <= age_d;
    end
  end

  // data and tag storage, written on write-hit merge or refill install
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[idx][way_sel] <= line_new;
      tag_q[idx][way_sel]  <= tag;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;
  assign wb_cnt         = wb_cnt_q;
endmodule

// File: tb/tb_l2_cache_wb.sv
// tb_l2_cache_wb: directed checks of l2_cache_wb hits, misses, eviction, LRU and reset
module tb_l2_cache_wb;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mem_lat = 3;
  int wcnt = 0;
  int n_rd = 0, n_wr = 0, n_resp = 0, n_both = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0] rd_addr = '0, wr_addr = '0;
  logic [127:0] wr_data = '0;

  always #5 clk = ~clk;

  l2_cache_wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .L1_WORDS(4), .BLOCK_WORDS(16)) bus();

  l2_cache_wb #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SETS(16), .NUM_WAYS(4),
    .BLOCK_WORDS(16), .L1_WORDS(4), .HIT_LATENCY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] blk(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // bus monitor: mem request starts, their addresses/data, overlap and response pulses
  always @(negedge clk) begin
    if (bus.mem_read && !prev_rd) begin n_rd++; rd_addr = bus.mem_addr; end
    if (bus.mem_write && !prev_wr) begin n_wr++; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata[127:0]; end
    if (bus.mem_read && bus.mem_write) n_both++;
    if (bus.resp_valid) n_resp++;
    prev_rd = bus.mem_read;
    prev_wr = bus.mem_write;
  end

  // memory: answers after mem_lat cycles, refill word i = (line address << 2) + i
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (rst_n && (bus.mem_read || bus.mem_write)) begin
        wcnt++;
        if (wcnt >= mem_lat) begin
          bus.mem_ready = 1'b1;
          wcnt = 0;
          for (int i = 0; i < 16; i++) bus.mem_rdata[i*32 +: 32] = (bus.mem_addr << 2) + 32'(i);
        end
      end else wcnt = 0;
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [127:0] wdata,
                        output logic hit, output logic [127:0] rdata, output int lat);
    int t0;
    int n;
    hit = 1'b0;
    rdata = '0;
    lat = -1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    t0 = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 200) begin @(negedge clk); n++; end
    if (bus.resp_valid) begin
      hit = bus.resp_hit;
      rdata = bus.resp_rdata;
      lat = cyc - t0;
    end else check("resp_timeout", 128'(bus.resp_valid), 128'd1);
  endtask

  initial begin
    logic h;
    logic [127:0] d;
    int lat, r0, w0, p0, n;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 128'(bus.req_ready), 128'd1);
    check("rst_resp_valid", 128'(bus.resp_valid), 128'd0);
    check("rst_mem_rw", 128'({bus.mem_read, bus.mem_write}), 128'd0);
    check("rst_counters", 128'({hit_cnt, miss_cnt, wb_cnt}), 128'd0);
    rst_n = 1'b1;

    // 1: cold read miss
    r0 = n_rd; w0 = n_wr;
    do_req(1'b0, 32'h40, '0, h, d, lat);
    check("t1_hit", 128'(h), 128'd0);
    check("t1_rdata", d, blk(32'h100));
    check("t1_rd_count", 128'(n_rd - r0), 128'd1);
    check("t1_rd_addr", 128'(rd_addr), 128'h40);
    check("t1_no_write", 128'(n_wr - w0), 128'd0);
    check("t1_miss_cnt", 128'(miss_cnt), 128'd1);

    // 2: hit on another sub-block of the same line
    r0 = n_rd; w0 = n_wr;
    do_req(1'b0, 32'h50, '0, h, d, lat);
    check("t2_latency", 128'(lat), 128'd3);
    check("t2_hit", 128'(h), 128'd1);
    check("t2_rdata", d, blk(32'h104));
    check("t2_no_mem", 128'((n_rd - r0) + (n_wr - w0)), 128'd0);
    check("t2_hit_cnt", 128'(hit_cnt), 128'd1);
    @(negedge clk);
    check("t2_ready_again", 128'(bus.req_ready), 128'd1);

    // 3: write hit then read back
    r0 = n_rd; w0 = n_wr;
    do_req(1'b1, 32'h40, blk(32'hAAAA0000), h, d, lat);
    check("t3_wr_hit", 128'(h), 128'd1);
    check("t3_wr_rdata", d, blk(32'hAAAA0000));
    do_req(1'b0, 32'h40, '0, h, d, lat);
    check("t3_rd_hit", 128'(h), 128'd1);
    check("t3_rd_rdata", d, blk(32'hAAAA0000));
    check("t3_no_mem", 128'((n_rd - r0) + (n_wr - w0)), 128'd0);

    // 4: fill set 0, dirty way 0, touch the others, then force eviction of 0x0000
    do_req(1'b0, 32'h0000, '0, h, d, lat);
    do_req(1'b0, 32'h0400, '0, h, d, lat);
    do_req(1'b0, 32'h0800, '0, h, d, lat);
    do_req(1'b0, 32'h0C00, '0, h, d, lat);
    do_req(1'b1, 32'h0000, blk(32'hBEEF0000), h, d, lat);
    check("t4_wr_hit", 128'(h), 128'd1);
    do_req(1'b0, 32'h0400, '0, h, d, lat);
    do_req(1'b0, 32'h0800, '0, h, d, lat);
    do_req(1'b0, 32'h0C00, '0, h, d, lat);
    check("t4_c00_hit", 128'(h), 128'd1);
    w0 = n_wr;
    do_req(1'b0, 32'h1000, '0, h, d, lat);
    check("t4_miss", 128'(h), 128'd0);
    check("t4_wr_count", 128'(n_wr - w0), 128'd1);
    check("t4_wr_addr", 128'(wr_addr), 128'h0);
    check("t4_wr_data", wr_data, blk(32'hBEEF0000));
    check("t4_rd_addr", 128'(rd_addr), 128'h1000);
    check("t4_rdata", d, blk(32'h4000));
    check("t4_wb_cnt", 128'(wb_cnt), 128'd1);

    // 5: next miss evicts the clean LRU way holding 0x0400
    r0 = n_rd; w0 = n_wr;
    do_req(1'b0, 32'h1400, '0, h, d, lat);
    check("t5_miss", 128'(h), 128'd0);
    check("t5_no_write", 128'(n_wr - w0), 128'd0);
    check("t5_rd_count", 128'(n_rd - r0), 128'd1);
    check("t5_rd_addr", 128'(rd_addr), 128'h1400);
    do_req(1'b0, 32'h0800, '0, h, d, lat);
    check("t5_0800_kept", 128'(h), 128'd1);
    do_req(1'b0, 32'h0400, '0, h, d, lat);
    check("t5_0400_evicted", 128'(h), 128'd0);
    check("t5_counts", 128'({hit_cnt, miss_cnt, wb_cnt}), {32'd0, 32'd8, 32'd8, 32'd1});

    // 6: reset in the middle of a stalled refill
    mem_lat = 1000;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h80;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.mem_read && n < 50) begin @(negedge clk); n++; end
    check("t6_mem_read_up", 128'(bus.mem_read), 128'd1);
    repeat (10) @(negedge clk);
    check("t6_mem_read_held", 128'(bus.mem_read), 128'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_mem_rw", 128'({bus.mem_read, bus.mem_write}), 128'd0);
    check("t6_rst_resp", 128'(bus.resp_valid), 128'd0);
    check("t6_rst_counters", 128'({hit_cnt, miss_cnt, wb_cnt}), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_lat = 3;
    p0 = n_resp;
    @(negedge clk);
    check("t6_ready", 128'(bus.req_ready), 128'd1);
    repeat (5) @(negedge clk);
    check("t6_no_resp", 128'(n_resp - p0), 128'd0);
    do_req(1'b0, 32'h40, '0, h, d, lat);
    check("t6_reread_miss", 128'(h), 128'd0);
    check("t6_reread_data", d, blk(32'h100));
    check("t6_miss_cnt", 128'(miss_cnt), 128'd1);

    check("rw_overlap", 128'(n_both), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
